// File: rtl/pipelined_fp_adder.sv
// pipelined_fp_adder: 4-stage floating-point adder/subtractor with a valid/ready
// stream interface. Number format is {exception, sign, exponent, fraction} with a
// hidden leading 1 for normal numbers. Stages: unpack/swap, align/add,
// normalise, round/pack. All stages advance together when the output slot is
// free or being consumed.
module pipelined_fp_adder #(
  parameter int size_mantissa        = 24,
  parameter int size_exponent        = 8,
  parameter int size_exception_field = 2,
  parameter int size_counter         = 5,
  parameter int tag_width            = 4,
  parameter int size = size_mantissa + size_exponent + size_exception_field
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 sub,
  input  logic [size-1:0]      a_number_i,
  input  logic [size-1:0]      b_number_i,
  input  logic [tag_width-1:0] tag_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [size-1:0]      resulted_number_o,
  output logic [tag_width-1:0] tag_o
);

  localparam int M  = size_mantissa;
  localparam int E  = size_exponent;
  localparam int X  = size_exception_field;
  localparam int W  = M + 3;  // mantissa plus guard, round, sticky
  localparam int EW = E + 2;  // signed exponent width used after normalisation

  localparam logic [X-1:0] EXC_ZERO   = X'(2'd0);
  localparam logic [X-1:0] EXC_NORMAL = X'(2'd1);
  localparam logic [X-1:0] EXC_INF    = X'(2'd2);
  localparam logic [X-1:0] EXC_NAN    = X'(2'd3);

  localparam logic [E-1:0]          SHIFT_ALL = E'(M + 2);
  localparam logic signed [EW-1:0]  EXP_ONE   = {{(EW-1){1'b0}}, 1'b1};
  localparam logic signed [EW-1:0]  EXP_ZERO  = {EW{1'b0}};
  localparam logic signed [EW-1:0]  EXP_MAX   = {2'b00, {E{1'b1}}};

  function automatic logic [size-1:0] pack(input logic [X-1:0] exc, input logic s,
                                           input logic [E-1:0] e, input logic [M-2:0] f);
    return {exc, s, e, f};
  endfunction

  // Leading-zero count; the highest set bit wins because it is visited last.
  function automatic logic [size_counter-1:0] lzc(input logic [W-1:0] v);
    logic [size_counter-1:0] cnt;
    cnt = size_counter'(W);
    for (int i = 0; i < W; i++) begin
      cnt = v[i] ? size_counter'(W - 1 - i) : cnt;
    end
    return cnt;
  endfunction

  logic advance;

  logic [X-1:0] exc_a, exc_b;
  logic         sgn_a, sgn_b, sgn_b_eff;
  logic [E-1:0] exp_a, exp_b;
  logic [M-2:0] frc_a, frc_b;

  logic                 s1_valid_d, s1_valid_q;
  logic [tag_width-1:0] s1_tag_d, s1_tag_q;
  logic                 s1_sign_d, s1_sign_q;
  logic                 s1_eff_op_d, s1_eff_op_q;
  logic [E-1:0]         s1_exp_x_d, s1_exp_x_q;
  logic [M-1:0]         s1_mant_x_d, s1_mant_x_q;
  logic [M-1:0]         s1_mant_y_d, s1_mant_y_q;
  logic [E-1:0]         s1_shift_d, s1_shift_q;
  logic                 s1_special_d, s1_special_q;
  logic [size-1:0]      s1_spec_num_d, s1_spec_num_q;

  logic [W-1:0]         x_field, y_field, y_aligned;
  logic [2*W-1:0]       y_wide;

  logic                 s2_valid_q;
  logic [tag_width-1:0] s2_tag_q;
  logic                 s2_sign_q;
  logic [E-1:0]         s2_exp_x_q;
  logic [W:0]           s2_sum_d, s2_sum_q;
  logic                 s2_special_q;
  logic [size-1:0]      s2_spec_num_q;

  logic [size_counter-1:0] lz;
  logic signed [EW-1:0]    exp_ext, lz_ext;

  logic                 s3_valid_q;
  logic [tag_width-1:0] s3_tag_q;
  logic                 s3_sign_q;
  logic signed [EW-1:0] s3_exp_d, s3_exp_q;
  logic [W-1:0]         s3_norm_d, s3_norm_q;
  logic                 s3_zero_d, s3_zero_q;
  logic                 s3_special_q;
  logic [size-1:0]      s3_spec_num_q;

  logic                 round_up;
  logic [M:0]           mant_rnd;
  logic [M-2:0]         frac_fin;
  logic signed [EW-1:0] exp_fin;

  logic                 out_valid_d, out_valid_q;
  logic [size-1:0]      res_d, res_q;
  logic [tag_width-1:0] tag_d, tag_q;

  assign advance           = ~out_valid_q | out_ready;
  assign in_ready          = advance;
  assign out_valid         = out_valid_q;
  assign resulted_number_o = res_q;
  assign tag_o             = tag_q;

  // Stage 1: unpack, order operands by magnitude, resolve special operands.
  always_comb begin
    exc_a = a_number_i[size-1 -: X];
    sgn_a = a_number_i[size-1-X];
    exp_a = a_number_i[size-2-X -: E];
    frc_a = a_number_i[M-2:0];
    exc_b = b_number_i[size-1 -: X];
    sgn_b = b_number_i[size-1-X];
    exp_b = b_number_i[size-2-X -: E];
    frc_b = b_number_i[M-2:0];
    sgn_b_eff   = sgn_b ^ sub;
    s1_valid_d  = in_valid;
    s1_tag_d    = tag_i;
    s1_eff_op_d = sgn_a ^ sgn_b ^ sub;
    if ({exp_a, frc_a} >= {exp_b, frc_b}) begin
      s1_sign_d   = sgn_a;
      s1_exp_x_d  = exp_a;
      s1_mant_x_d = {1'b1, frc_a};
      s1_mant_y_d = {1'b1, frc_b};
      s1_shift_d  = exp_a - exp_b;
    end else begin
      s1_sign_d   = sgn_b_eff;
      s1_exp_x_d  = exp_b;
      s1_mant_x_d = {1'b1, frc_b};
      s1_mant_y_d = {1'b1, frc_a};
      s1_shift_d  = exp_b - exp_a;
    end
    s1_special_d  = 1'b1;
    s1_spec_num_d = {size{1'b0}};
    if (exc_a == EXC_NAN || exc_b == EXC_NAN) begin
      s1_spec_num_d = pack(EXC_NAN, 1'b0, {E{1'b0}}, {(M-1){1'b0}});
    end else if (exc_a == EXC_INF && exc_b == EXC_INF) begin
      s1_spec_num_d = s1_eff_op_d ? pack(EXC_NAN, 1'b0, {E{1'b0}}, {(M-1){1'b0}})
                                  : pack(EXC_INF, sgn_a, {E{1'b0}}, {(M-1){1'b0}});
    end else if (exc_a == EXC_INF) begin
      s1_spec_num_d = pack(EXC_INF, sgn_a, {E{1'b0}}, {(M-1){1'b0}});
    end else if (exc_b == EXC_INF) begin
      s1_spec_num_d = pack(EXC_INF, sgn_b_eff, {E{1'b0}}, {(M-1){1'b0}});
    end else if (exc_a == EXC_ZERO && exc_b == EXC_ZERO) begin
      s1_spec_num_d = pack(EXC_ZERO, sgn_a & sgn_b_eff, {E{1'b0}}, {(M-1){1'b0}});
    end else if (exc_a == EXC_ZERO) begin
      s1_spec_num_d = pack(exc_b, sgn_b_eff, exp_b, frc_b);
    end else if (exc_b == EXC_ZERO) begin
      s1_spec_num_d = a_number_i;
    end else begin
      s1_special_d  = 1'b0;
      s1_spec_num_d = {size{1'b0}};
    end
  end

  // Stage 1 register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;  s1_tag_q <= '0;  s1_sign_q <= 1'b0;  s1_eff_op_q <= 1'b0;
      s1_exp_x_q <= '0;  s1_mant_x_q <= '0;  s1_mant_y_q <= '0;  s1_shift_q <= '0;
      s1_special_q <= 1'b0;  s1_spec_num_q <= '0;
    end else if (advance) begin
      s1_valid_q <= s1_valid_d;  s1_tag_q <= s1_tag_d;  s1_sign_q <= s1_sign_d;
      s1_eff_op_q <= s1_eff_op_d;  s1_exp_x_q <= s1_exp_x_d;  s1_mant_x_q <= s1_mant_x_d;
      s1_mant_y_q <= s1_mant_y_d;  s1_shift_q <= s1_shift_d;
      s1_special_q <= s1_special_d;  s1_spec_num_q <= s1_spec_num_d;
    end
  end

  // Stage 2: align the smaller operand (bits shifted out collapse into sticky), then add/subtract.
  always_comb begin
    x_field = {s1_mant_x_q, 3'b000};
    y_field = {s1_mant_y_q, 3'b000};
    y_wide  = {y_field, {W{1'b0}}} >> s1_shift_q;
    if (s1_shift_q >= SHIFT_ALL) begin
      y_aligned = {{(W-1){1'b0}}, 1'b1};
    end else begin
      y_aligned = y_wide[2*W-1:W] | {{(W-1){1'b0}}, |y_wide[W-1:0]};
    end
    if (s1_eff_op_q) begin
      s2_sum_d = {1'b0, x_field} - {1'b0, y_aligned};
    end else begin
      s2_sum_d = {1'b0, x_field} + {1'b0, y_aligned};
    end
  end

  // Stage 2 register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;  s2_tag_q <= '0;  s2_sign_q <= 1'b0;  s2_exp_x_q <= '0;
      s2_sum_q <= '0;  s2_special_q <= 1'b0;  s2_spec_num_q <= '0;
    end else if (advance) begin
      s2_valid_q <= s1_valid_q;  s2_tag_q <= s1_tag_q;  s2_sign_q <= s1_sign_q;
      s2_exp_x_q <= s1_exp_x_q;  s2_sum_q <= s2_sum_d;
      s2_special_q <= s1_special_q;  s2_spec_num_q <= s1_spec_num_q;
    end
  end

  // Stage 3: normalise; a carry shifts right by one, otherwise shift out leading zeros.
  always_comb begin
    lz        = lzc(s2_sum_q[W-1:0]);
    exp_ext   = {2'b00, s2_exp_x_q};
    lz_ext    = EW'(lz);
    s3_zero_d = (s2_sum_q == {(W+1){1'b0}});
    if (s2_sum_q[W]) begin
      s3_norm_d = {s2_sum_q[W:2], s2_sum_q[1] | s2_sum_q[0]};
      s3_exp_d  = exp_ext + EXP_ONE;
    end else begin
      s3_norm_d = s2_sum_q[W-1:0] << lz;
      s3_exp_d  = exp_ext - lz_ext;
    end
  end

  // Stage 3 register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s3_valid_q <= 1'b0;  s3_tag_q <= '0;  s3_sign_q <= 1'b0;  s3_exp_q <= '0;
      s3_norm_q <= '0;  s3_zero_q <= 1'b0;  s3_special_q <= 1'b0;  s3_spec_num_q <= '0;
    end else if (advance) begin
      s3_valid_q <= s2_valid_q;  s3_tag_q <= s2_tag_q;  s3_sign_q <= s2_sign_q;
      s3_exp_q <= s3_exp_d;  s3_norm_q <= s3_norm_d;  s3_zero_q <= s3_zero_d;
      s3_special_q <= s2_special_q;  s3_spec_num_q <= s2_spec_num_q;
    end
  end

  // Stage 4: round to nearest even, renormalise on mantissa overflow, classify and pack.
  always_comb begin
    round_up    = s3_norm_q[2] & (s3_norm_q[1] | s3_norm_q[0] | s3_norm_q[3]);
    mant_rnd    = {1'b0, s3_norm_q[W-1:3]} + {{M{1'b0}}, round_up};
    out_valid_d = s3_valid_q;
    tag_d       = s3_tag_q;
    if (mant_rnd[M]) begin
      frac_fin = mant_rnd[M-1:1];
      exp_fin  = s3_exp_q + EXP_ONE;
    end else begin
      frac_fin = mant_rnd[M-2:0];
      exp_fin  = s3_exp_q;
    end
    if (s3_special_q) begin
      res_d = s3_spec_num_q;
    end else if (s3_zero_q) begin
      res_d = pack(EXC_ZERO, 1'b0, {E{1'b0}}, {(M-1){1'b0}});
    end else if (exp_fin >= EXP_MAX) begin
      res_d = pack(EXC_INF, s3_sign_q, {E{1'b0}}, {(M-1){1'b0}});
    end else if (exp_fin <= EXP_ZERO) begin
      res_d = pack(EXC_ZERO, s3_sign_q, {E{1'b0}}, {(M-1){1'b0}});
    end else begin
      res_d = pack(EXC_NORMAL, s3_sign_q, exp_fin[E-1:0], frac_fin);
    end
  end

  // Output register; holds steady while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;  res_q <= '0;  tag_q <= '0;
    end else if (advance) begin
      out_valid_q <= out_valid_d;  res_q <= res_d;  tag_q <= tag_d;
    end
  end

endmodule

// File: tb/tb_pipelined_fp_adder.sv
// Directed self-checking bench for pipelined_fp_adder (default parameters).
module tb_pipelined_fp_adder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        sub;
  logic [33:0] a_num;
  logic [33:0] b_num;
  logic [3:0]  tag_in;
  logic        out_valid;
  logic        out_ready;
  logic [33:0] res;
  logic [3:0]  tag_out;

  int n_vec = 0;
  int n_err = 0;
  int sent;
  int rcv;

  pipelined_fp_adder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sub(sub),
    .a_number_i(a_num), .b_number_i(b_num), .tag_i(tag_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .resulted_number_o(res), .tag_o(tag_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [33:0] pk(input logic [1:0] x, input logic s,
                                     input logic [7:0] e, input logic [22:0] f);
    return {x, s, e, f};
  endfunction

  task automatic check(input string nm, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", nm, obs, expv);
    end
  endtask

  // One isolated operation: drive, wait (bounded) for the result, check latency/value/tag.
  task automatic run_op(input string nm, input logic [33:0] a, input logic [33:0] b,
                        input logic s, input logic [3:0] t, input logic [33:0] expv);
    int cyc;
    in_valid = 1'b1; a_num = a; b_num = b; sub = s; tag_in = t;
    check({nm, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 12) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({nm, "_latency"}, 64'(cyc), 64'd4);
    check({nm, "_result"}, 64'(res), 64'(expv));
    check({nm, "_tag"}, 64'(tag_out), 64'(t));
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; sub = 1'b0; a_num = '0; b_num = '0;
    tag_in = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(res), 64'd0);
    check("rst_tag", 64'(tag_out), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    run_op("one_plus_one", pk(2'd1,1'b0,8'd127,23'd0), pk(2'd1,1'b0,8'd127,23'd0), 1'b0, 4'd3,
           pk(2'd1,1'b0,8'd128,23'd0));
    run_op("one_minus_one", pk(2'd1,1'b0,8'd127,23'd0), pk(2'd1,1'b0,8'd127,23'd0), 1'b1, 4'd5,
           pk(2'd0,1'b0,8'd0,23'd0));
    run_op("tie_even_down", pk(2'd1,1'b0,8'd127,23'd0), pk(2'd1,1'b0,8'd103,23'd0), 1'b0, 4'd6,
           pk(2'd1,1'b0,8'd127,23'd0));
    run_op("tie_even_up", pk(2'd1,1'b0,8'd127,23'd1), pk(2'd1,1'b0,8'd103,23'd0), 1'b0, 4'd7,
           pk(2'd1,1'b0,8'd127,23'd2));
    run_op("above_half_up", pk(2'd1,1'b0,8'd127,23'd0), pk(2'd1,1'b0,8'd103,23'd1), 1'b0, 4'd8,
           pk(2'd1,1'b0,8'd127,23'd1));
    run_op("far_sticky_only", pk(2'd1,1'b0,8'd127,23'd0), pk(2'd1,1'b0,8'd97,23'd0), 1'b0, 4'd9,
           pk(2'd1,1'b0,8'd127,23'd0));
    run_op("one_minus_two", pk(2'd1,1'b0,8'd127,23'd0), pk(2'd1,1'b0,8'd128,23'd0), 1'b1, 4'd10,
           pk(2'd1,1'b1,8'd127,23'd0));
    run_op("inf_plus_neginf", pk(2'd2,1'b0,8'd0,23'd0), pk(2'd2,1'b1,8'd0,23'd0), 1'b0, 4'd11,
           pk(2'd3,1'b0,8'd0,23'd0));
    run_op("nan_plus_one", pk(2'd3,1'b0,8'd0,23'd0), pk(2'd1,1'b0,8'd127,23'd0), 1'b0, 4'd12,
           pk(2'd3,1'b0,8'd0,23'd0));
    run_op("max_exp_overflow", pk(2'd1,1'b0,8'd254,23'd0), pk(2'd1,1'b0,8'd254,23'd0), 1'b0, 4'd13,
           pk(2'd2,1'b0,8'd0,23'd0));
    run_op("one_minus_neginf", pk(2'd1,1'b0,8'd127,23'd0), pk(2'd2,1'b1,8'd0,23'd0), 1'b1, 4'd14,
           pk(2'd2,1'b0,8'd0,23'd0));
    run_op("zero_minus_one", pk(2'd0,1'b0,8'd0,23'd0), pk(2'd1,1'b0,8'd127,23'd0), 1'b1, 4'd15,
           pk(2'd1,1'b1,8'd127,23'd0));
    run_op("negzero_minus_zero", pk(2'd0,1'b1,8'd0,23'd0), pk(2'd0,1'b0,8'd0,23'd0), 1'b1, 4'd1,
           pk(2'd0,1'b1,8'd0,23'd0));

    // Back-pressure: stream 8 ops, consumer stalls in cycles 6..9.
    sent = 0; rcv = 0;
    for (int cyc = 0; cyc < 40 && rcv < 8; cyc++) begin
      out_ready = !(cyc >= 6 && cyc <= 9);
      in_valid  = (sent < 8);
      a_num  = pk(2'd1, 1'b0, 8'd130, 23'(2 * sent));
      b_num  = pk(2'd1, 1'b0, 8'd130, 23'd0);
      sub    = 1'b0;
      tag_in = 4'(sent);
      @(negedge clk);
      if (cyc >= 6 && cyc <= 9) check("bp_in_ready_low", 64'(in_ready), 64'd0);
      if (out_valid === 1'b1) begin
        check("bp_result", 64'(res), 64'(pk(2'd1, 1'b0, 8'd131, 23'(rcv))));
        check("bp_tag", 64'(tag_out), 64'(rcv));
        if (out_ready) rcv++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_received", 64'(rcv), 64'd8);
    check("bp_sent", 64'(sent), 64'd8);

    // Reset with three operations in flight: none may emerge.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a_num = pk(2'd1,1'b0,8'd127,23'd0); b_num = pk(2'd1,1'b0,8'd127,23'd0);
      sub = 1'b0; tag_in = 4'(i + 2);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("midrst_no_output", 64'(out_valid), 64'd0);
    end
    run_op("after_rst", pk(2'd1,1'b0,8'd128,23'd0), pk(2'd1,1'b0,8'd127,23'd0), 1'b0, 4'd4,
           pk(2'd1,1'b0,8'd128,23'h400000));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
